// File: rtl/psk_acq_pkg.sv
// Shared types and constants for the PSK acquisition sequencer.
// The quadrature offset is applied by the Q NCO wiring, not by the sequencer.
package psk_acq_pkg;

    localparam int CW_W_DEF = 13;
    localparam int E_W_DEF  = 9;

    localparam logic [CW_W_DEF-1:0] QUAD_OFS = 13'h800;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_INTEG,
        S_DUMP,
        S_CMP,
        S_NEXT,
        S_REPORT
    } state_t;

endpackage

// File: rtl/psk_peak_tracker.sv
// Samples one energy per grid point and keeps the strongest point of the sweep.
// Ties keep the earliest point because the compare is strict.
module psk_peak_tracker
    import psk_acq_pkg::*;
#(
    parameter int              CW_W     = CW_W_DEF,
    parameter int              E_W      = E_W_DEF,
    parameter logic [CW_W-1:0] INIT_FCW = '0
) (
    input  logic            clk,
    input  logic            rst_in,
    input  logic            clr,
    input  logic            smp_en,
    input  logic            cmp_en,
    input  logic [E_W-1:0]  energy_in,
    input  logic [CW_W-1:0] cur_fcw,
    input  logic [CW_W-1:0] cur_pcw,
    output logic [E_W-1:0]  best_e,
    output logic [CW_W-1:0] best_fcw,
    output logic [CW_W-1:0] best_pcw
);

    logic [E_W-1:0] e_smp;

    always_ff @(posedge clk) begin
        if (!rst_in) begin
            e_smp    <= '0;
            best_e   <= '0;
            best_fcw <= INIT_FCW;
            best_pcw <= '0;
        end else begin
            if (smp_en)
                e_smp <= energy_in;
            if (clr) begin
                best_e   <= '0;
                best_fcw <= INIT_FCW;
                best_pcw <= '0;
            end else if (cmp_en && (e_smp > best_e)) begin
                best_e   <= e_smp;
                best_fcw <= cur_fcw;
                best_pcw <= cur_pcw;
            end
        end
    end

endmodule

// File: rtl/psk_sweep_ctl.sv
// Acquisition sequencer: walks the bin x phase grid, integrates each point,
// and reports the peak (fcw, pcw, energy) once per sweep over valid/ready.
module psk_sweep_ctl
    import psk_acq_pkg::*;
#(
    parameter int              CW_W      = CW_W_DEF,
    parameter logic [CW_W-1:0] FCW_START = 'h100,
    parameter logic [CW_W-1:0] FCW_STEP  = 'h010,
    parameter int              NUM_BINS  = 8,
    parameter int              NUM_PH    = 4,
    parameter logic [CW_W-1:0] PH_STEP   = 'h400,
    parameter int              SETTLE    = 4,
    parameter int              INTEG_LEN = 256,
    parameter int              E_W       = E_W_DEF,
    parameter logic [E_W-1:0]  THRESH    = 'h040
) (
    input  logic            clk,
    input  logic            rst_in,
    input  logic            start,
    input  logic            abort,
    input  logic [E_W-1:0]  energy_in,
    output logic [CW_W-1:0] fcw,
    output logic [CW_W-1:0] pcw,
    output logic            corr_clr,
    output logic            busy,
    output logic            res_valid,
    input  logic            res_ready,
    output logic            res_found,
    output logic [CW_W-1:0] res_fcw,
    output logic [CW_W-1:0] res_pcw,
    output logic [E_W-1:0]  res_energy
);

    localparam int CNT_MAX = (SETTLE > INTEG_LEN) ? SETTLE : INTEG_LEN;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int BIN_W   = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
    localparam int PH_W    = (NUM_PH > 1) ? $clog2(NUM_PH) : 1;

    localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] INT_LAST = CNT_W'(INTEG_LEN - 1);
    localparam logic [BIN_W-1:0] BIN_LAST = BIN_W'(NUM_BINS - 1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(NUM_PH - 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [BIN_W-1:0] bin_idx;
    logic [PH_W-1:0]  ph_idx;
    logic             last_pt;
    logic             trk_clr;
    logic [E_W-1:0]   best_e;
    logic [CW_W-1:0]  best_fcw;
    logic [CW_W-1:0]  best_pcw;

    assign last_pt = (bin_idx == BIN_LAST) && (ph_idx == PH_LAST);
    assign trk_clr = (state == S_IDLE) && (state_nx == S_SETTLE);

    always_comb begin
        state_nx  = state;
        corr_clr  = 1'b0;
        busy      = 1'b1;
        res_valid = 1'b0;
        unique case (state)
            S_IDLE: begin
                busy     = 1'b0;
                corr_clr = 1'b1;
                if (start && !abort)
                    state_nx = S_SETTLE;
            end
            S_SETTLE: begin
                corr_clr = 1'b1;
                if (cnt == SET_LAST)
                    state_nx = S_INTEG;
            end
            S_INTEG: begin
                if (cnt == INT_LAST)
                    state_nx = S_DUMP;
            end
            S_DUMP:   state_nx = S_CMP;
            S_CMP:    state_nx = S_NEXT;
            S_NEXT:   state_nx = last_pt ? S_REPORT : S_SETTLE;
            S_REPORT: begin
                corr_clr  = 1'b1;
                res_valid = 1'b1;
                if (res_ready)
                    state_nx = S_IDLE;
            end
            default:  state_nx = S_IDLE;
        endcase
        if (abort && (state != S_IDLE))
            state_nx = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_in) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bin_idx    <= '0;
            ph_idx     <= '0;
            fcw        <= FCW_START;
            pcw        <= '0;
            res_found  <= 1'b0;
            res_fcw    <= '0;
            res_pcw    <= '0;
            res_energy <= '0;
        end else begin
            state <= state_nx;
            cnt   <= (state_nx != state) ? '0 : cnt + 1'b1;
            // Grid restarts from point 0 whenever the sequencer is or goes idle.
            if ((state == S_IDLE) || (state_nx == S_IDLE)) begin
                bin_idx <= '0;
                ph_idx  <= '0;
                fcw     <= FCW_START;
                pcw     <= '0;
            end else if (state == S_NEXT) begin
                if (ph_idx != PH_LAST) begin
                    ph_idx <= ph_idx + 1'b1;
                    pcw    <= pcw + PH_STEP;
                end else begin
                    ph_idx  <= '0;
                    pcw     <= '0;
                    bin_idx <= bin_idx + 1'b1;
                    fcw     <= fcw + FCW_STEP;
                end
            end
            if ((state == S_NEXT) && (state_nx == S_REPORT)) begin
                res_found  <= (best_e >= THRESH);
                res_fcw    <= best_fcw;
                res_pcw    <= best_pcw;
                res_energy <= best_e;
            end
        end
    end

    psk_peak_tracker #(
        .CW_W     (CW_W),
        .E_W      (E_W),
        .INIT_FCW (FCW_START)
    ) u_peak (
        .clk       (clk),
        .rst_in    (rst_in),
        .clr       (trk_clr),
        .smp_en    (state == S_DUMP),
        .cmp_en    (state == S_CMP),
        .energy_in (energy_in),
        .cur_fcw   (fcw),
        .cur_pcw   (pcw),
        .best_e    (best_e),
        .best_fcw  (best_fcw),
        .best_pcw  (best_pcw)
    );

endmodule

// File: tb/tb_psk_sweep_ctl.sv
// Bench for psk_sweep_ctl: vector table, random sweeps against an argmax
// model, and directed abort / stall / wrap / clear-timing sequences.
module tb_psk_sweep_ctl;

    localparam int PT_A   = 4;
    localparam int COST_A = 9;
    localparam int LAT_A  = PT_A * COST_A;
    localparam int COST_B = 8;
    localparam int LAT_B  = 6 * COST_B;

    typedef struct packed {
        logic [12:0] fcw;
        logic [12:0] pcw;
        logic [8:0]  e;
        logic        found;
    } exp_t;

    typedef struct packed {
        logic [3:0][8:0] en;
        exp_t            ex;
    } vec_t;

    logic clk = 1'b0;
    logic rst_in = 1'b0;

    logic        a_start = 0, a_abort = 0, a_ready = 0;
    logic [8:0]  a_energy = '0;
    logic [12:0] a_fcw, a_pcw, a_rfcw, a_rpcw;
    logic        a_clr, a_busy, a_valid, a_found;
    logic [8:0]  a_re;

    logic        b_start = 0, b_abort = 0, b_ready = 0;
    logic [8:0]  b_energy = '0;
    logic [12:0] b_fcw, b_pcw, b_rfcw, b_rpcw;
    logic        b_clr, b_busy, b_valid, b_found;
    logic [8:0]  b_re;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    psk_sweep_ctl #(
        .NUM_BINS (2), .NUM_PH (2), .SETTLE (2), .INTEG_LEN (4)
    ) dut_a (
        .clk (clk), .rst_in (rst_in), .start (a_start), .abort (a_abort),
        .energy_in (a_energy), .fcw (a_fcw), .pcw (a_pcw),
        .corr_clr (a_clr), .busy (a_busy), .res_valid (a_valid),
        .res_ready (a_ready), .res_found (a_found), .res_fcw (a_rfcw),
        .res_pcw (a_rpcw), .res_energy (a_re)
    );

    psk_sweep_ctl #(
        .FCW_START (13'h1FF0), .FCW_STEP (13'h20),
        .NUM_BINS (3), .NUM_PH (2), .SETTLE (3), .INTEG_LEN (2)
    ) dut_b (
        .clk (clk), .rst_in (rst_in), .start (b_start), .abort (b_abort),
        .energy_in (b_energy), .fcw (b_fcw), .pcw (b_pcw),
        .corr_clr (b_clr), .busy (b_busy), .res_valid (b_valid),
        .res_ready (b_ready), .res_found (b_found), .res_fcw (b_rfcw),
        .res_pcw (b_rpcw), .res_energy (b_re)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Point p = bin*2 + ph; strongest energy wins, earliest on ties.
    function automatic exp_t model_a(input logic [3:0][8:0] en);
        exp_t m;
        int best = 0;
        int bi = 0;
        for (int p = 0; p < PT_A; p++)
            if (int'(en[p]) > best) begin
                best = int'(en[p]);
                bi = p;
            end
        m.fcw   = 13'('h100 + (bi / 2) * 'h10);
        m.pcw   = 13'((bi % 2) * 'h400);
        m.e     = 9'(best);
        m.found = (best >= 'h40);
        return m;
    endfunction

    // Caller is at a negedge with dut_a idle; returns in REPORT, unacked.
    task automatic a_run(input logic [3:0][8:0] en, input exp_t ex,
                         input int stall, input bit poke);
        a_start = 1'b1;
        a_energy = en[0];
        @(negedge clk);
        a_start = 1'b0;
        for (int k = 0; k < LAT_A; k++) begin
            a_energy = en[k / COST_A];
            a_start = poke && (k == 1 || k == 4 || k == 30);
            if (k == 0) begin
                chk("w0_fcw", a_fcw, 13'h100);
                chk("w0_pcw", a_pcw, 13'h0);
            end
            if (k == 27) begin
                chk("w3_fcw", a_fcw, 13'h110);
                chk("w3_pcw", a_pcw, 13'h400);
            end
            if (k == LAT_A - 1)
                chk("lat_pre", a_valid, 1'b0);
            @(negedge clk);
        end
        a_start = 1'b0;
        chk("lat_valid", a_valid, 1'b1);
        for (int s = 0; s < stall; s++) begin
            a_start = poke;
            @(negedge clk);
            chk("stall_valid", a_valid, 1'b1);
            chk("stall_fcw", a_rfcw, ex.fcw);
        end
        a_start = 1'b0;
        chk("res_fcw", a_rfcw, ex.fcw);
        chk("res_pcw", a_rpcw, ex.pcw);
        chk("res_energy", a_re, ex.e);
        chk("res_found", a_found, ex.found);
    endtask

    task automatic a_ack(input exp_t ex);
        a_ready = 1'b1;
        @(negedge clk);
        a_ready = 1'b0;
        chk("ack_valid", a_valid, 1'b0);
        chk("ack_busy", a_busy, 1'b0);
        chk("ack_clr", a_clr, 1'b1);
        chk("ack_hold", a_re, ex.e);
    endtask

    vec_t tbl [6];

    initial begin
        logic [3:0][8:0] ren;
        exp_t            rex;
        int              mism;

        tbl[0] = '{en: {9'd50, 9'd30, 9'd50, 9'd10},
                   ex: '{13'h100, 13'h400, 9'd50, 1'b0}};
        tbl[1] = '{en: {9'd50, 9'h80, 9'd50, 9'd10},
                   ex: '{13'h110, 13'h000, 9'h80, 1'b1}};
        tbl[2] = '{en: {9'd0, 9'd0, 9'd0, 9'd0},
                   ex: '{13'h100, 13'h000, 9'd0, 1'b0}};
        tbl[3] = '{en: {9'h1FF, 9'd5, 9'd5, 9'd5},
                   ex: '{13'h110, 13'h400, 9'h1FF, 1'b1}};
        tbl[4] = '{en: {9'd0, 9'd0, 9'h3F, 9'h40},
                   ex: '{13'h100, 13'h000, 9'h40, 1'b1}};
        tbl[5] = '{en: {9'd3, 9'd2, 9'd1, 9'h3F},
                   ex: '{13'h100, 13'h000, 9'h3F, 1'b0}};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", a_busy, 1'b0);
        chk("rst_clr", a_clr, 1'b1);
        chk("rst_fcw", a_fcw, 13'h100);
        chk("rst_pcw", a_pcw, 13'h0);
        chk("rst_valid", a_valid, 1'b0);
        chk("rst_res", {a_found, a_rfcw, a_rpcw, a_re}, 32'h0);
        chk("rst_b_fcw", b_fcw, 13'h1FF0);
        rst_in = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            a_run(tbl[i].en, tbl[i].ex, 0, 1'b0);
            a_ack(tbl[i].ex);
        end

        // Stalled consumer with start pulses in SETTLE, INTEG and REPORT.
        a_run(tbl[1].en, tbl[1].ex, 10, 1'b1);
        a_ack(tbl[1].ex);

        // Abort during INTEG of point 2.
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        repeat (21) @(negedge clk);
        a_abort = 1'b1;
        @(negedge clk);
        a_abort = 1'b0;
        chk("abort_busy", a_busy, 1'b0);
        chk("abort_clr", a_clr, 1'b1);
        chk("abort_fcw", a_fcw, 13'h100);
        chk("abort_pcw", a_pcw, 13'h0);
        repeat (LAT_A) @(negedge clk);
        chk("abort_novalid", a_valid, 1'b0);
        a_run(tbl[0].en, tbl[0].ex, 0, 1'b0);

        // Abort in REPORT.
        a_abort = 1'b1;
        @(negedge clk);
        a_abort = 1'b0;
        chk("abort_rep_valid", a_valid, 1'b0);
        chk("abort_rep_busy", a_busy, 1'b0);

        // start together with abort in IDLE.
        a_start = 1'b1;
        a_abort = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        a_abort = 1'b0;
        chk("start_abort_idle", a_busy, 1'b0);

        // Reset mid-sweep.
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        repeat (12) @(negedge clk);
        rst_in = 1'b0;
        @(negedge clk);
        rst_in = 1'b1;
        chk("midrst_busy", a_busy, 1'b0);
        chk("midrst_fcw", a_fcw, 13'h100);
        chk("midrst_pcw", a_pcw, 13'h0);
        @(negedge clk);

        // Random sweeps against the argmax model.
        for (int r = 0; r < 20; r++) begin
            for (int p = 0; p < PT_A; p++)
                ren[p] = ($urandom_range(0, 3) == 0) ? 9'h40
                                                     : 9'($urandom_range(0, 'h7F));
            rex = model_a(ren);
            a_run(ren, rex, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            a_ack(rex);
        end

        // Instance B: fcw wrap across bins and exact corr_clr timing.
        b_energy = 9'h50;
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        mism = 0;
        for (int k = 0; k < LAT_B; k++) begin
            if (b_clr !== ((k % COST_B) < 3))
                mism++;
            if (k == 8) begin
                chk("b_p1_fcw", b_fcw, 13'h1FF0);
                chk("b_p1_pcw", b_pcw, 13'h400);
            end
            if (k == 16) begin
                chk("b_bin1_fcw", b_fcw, 13'h0010);
                chk("b_bin1_pcw", b_pcw, 13'h0);
            end
            if (k == 32)
                chk("b_bin2_fcw", b_fcw, 13'h0030);
            if (k == LAT_B - 1)
                chk("b_lat_pre", b_valid, 1'b0);
            @(negedge clk);
        end
        chk("b_clr_pattern", 32'(mism), 32'd0);
        chk("b_lat_valid", b_valid, 1'b1);
        chk("b_res_fcw", b_rfcw, 13'h1FF0);
        chk("b_res_pcw", b_rpcw, 13'h0);
        chk("b_res_energy", b_re, 9'h50);
        chk("b_res_found", b_found, 1'b1);
        b_ready = 1'b1;
        @(negedge clk);
        b_ready = 1'b0;
        chk("b_ack_busy", b_busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
